// File: rtl/ctrl_ram_datos_pkg.sv
// Shared definitions for the data-RAM load/store controller: RV32I size codes,
// FSM state encoding and the request legality check.
package pkg_mem;

  localparam int ANCHO_PALABRA = 32;

  localparam logic [2:0] TAM_B  = 3'b000;
  localparam logic [2:0] TAM_H  = 3'b001;
  localparam logic [2:0] TAM_W  = 3'b010;
  localparam logic [2:0] TAM_BU = 3'b100;
  localparam logic [2:0] TAM_HU = 3'b101;

  typedef enum logic [2:0] {
    INACTIVO = 3'd0,
    LEER     = 3'd1,
    ESPERA   = 3'd2,
    ESCRIBIR = 3'd3,
    FIN      = 3'd4
  } estado_t;

  // Stores have no unsigned variants, so BU/HU are only legal on loads.
  function automatic logic acceso_invalido(input logic       escribe,
                                           input logic [2:0] tam,
                                           input logic [1:0] byte_bajo);
    logic mal;
    mal = 1'b0;
    case (tam)
      TAM_B:   mal = 1'b0;
      TAM_BU:  mal = escribe;
      TAM_H:   mal = byte_bajo[0];
      TAM_HU:  mal = escribe | byte_bajo[0];
      TAM_W:   mal = |byte_bajo;
      default: mal = 1'b1;
    endcase
    return mal;
  endfunction

endpackage

// File: rtl/ctrl_ram_datos_if.sv
// Core-side request/response bundle of the load/store controller.
// master = memory stage of the core, slave = ctrl_ram_datos.
interface ctrl_ram_datos_if;
  import pkg_mem::*;

  logic                     sol;
  logic                     escribe;
  logic [2:0]               tam;
  logic [31:0]              dir;
  logic [ANCHO_PALABRA-1:0] dato_in;
  logic                     listo;
  logic                     error;
  logic [ANCHO_PALABRA-1:0] dato_out;

  modport master (
    output sol, escribe, tam, dir, dato_in,
    input  listo, error, dato_out
  );

  modport slave (
    input  sol, escribe, tam, dir, dato_in,
    output listo, error, dato_out
  );

endinterface

// File: rtl/ctrl_ram_datos_alinear_bytes.sv
// Byte-lane steering: extracts/extends a load from a RAM word and merges
// byte/half store data into a RAM word. Purely combinational.
module alinear_bytes
  import pkg_mem::*;
(
  input  logic [ANCHO_PALABRA-1:0] palabra,
  input  logic [2:0]               tam,
  input  logic [1:0]               carril,
  input  logic [15:0]              dato_st,
  output logic [ANCHO_PALABRA-1:0] carga,
  output logic [ANCHO_PALABRA-1:0] fusion
);

  logic [7:0]  byte_sel;
  logic [15:0] media_sel;

  always_comb begin
    byte_sel  = palabra[{carril, 3'b000} +: 8];
    media_sel = carril[1] ? palabra[31:16] : palabra[15:0];
    carga     = palabra;
    fusion    = palabra;
    // tam[2] marks the unsigned variants, so it masks the sign bit.
    case (tam[1:0])
      2'b00: begin
        carga = {{24{byte_sel[7] & ~tam[2]}}, byte_sel};
        fusion[{carril, 3'b000} +: 8] = dato_st[7:0];
      end
      2'b01: begin
        carga = {{16{media_sel[15] & ~tam[2]}}, media_sel};
        if (carril[1]) fusion[31:16] = dato_st;
        else           fusion[15:0]  = dato_st;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_ram_datos.sv
// Load/store controller between the core memory stage and a word-wide sync RAM;
// sub-word stores are done as read-modify-write. Define CTRL_RAM_RANGO_EN to
// reject addresses beyond the RAM instead of aliasing them.
module ctrl_ram_datos
  import pkg_mem::*;
#(
  parameter int ANCHO_DIR = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  ctrl_ram_datos_if.slave          nucleo,
  output logic [ANCHO_DIR-1:0]     ram_dir_w,
  output logic                     ram_hab_w,
  output logic [ANCHO_PALABRA-1:0] ram_dat_w,
  output logic [ANCHO_DIR-1:0]     ram_dir_r,
  output logic                     ram_hab_r,
  input  logic [ANCHO_PALABRA-1:0] ram_dat_r
);

  estado_t                  estado_q,   estado_d;
  logic                     escribe_q,  escribe_d;
  logic [2:0]               tam_q,      tam_d;
  logic [ANCHO_DIR+1:0]     dir_q,      dir_d;
  logic [ANCHO_PALABRA-1:0] dato_w_q,   dato_w_d;
  logic [ANCHO_PALABRA-1:0] dato_out_q, dato_out_d;
  logic                     error_q,    error_d;

  logic                     listo;
  logic                     err_nuevo;
  logic                     fuera_rango;
  logic [ANCHO_PALABRA-1:0] carga;
  logic [ANCHO_PALABRA-1:0] fusion;

`ifdef CTRL_RAM_RANGO_EN
  assign fuera_rango = |(nucleo.dir >> (ANCHO_DIR + 2));
`else
  logic unused_dir_alto;
  assign unused_dir_alto = |(nucleo.dir >> (ANCHO_DIR + 2));
  assign fuera_rango     = 1'b0;
`endif

  assign err_nuevo = acceso_invalido(nucleo.escribe, nucleo.tam, nucleo.dir[1:0])
                     | fuera_rango;

  alinear_bytes u_alinear (
    .palabra (ram_dat_r),
    .tam     (tam_q),
    .carril  (dir_q[1:0]),
    .dato_st (dato_w_q[15:0]),
    .carga   (carga),
    .fusion  (fusion)
  );

  always_comb begin
    estado_d   = estado_q;
    escribe_d  = escribe_q;
    tam_d      = tam_q;
    dir_d      = dir_q;
    dato_w_d   = dato_w_q;
    dato_out_d = dato_out_q;
    error_d    = error_q;
    ram_hab_r  = 1'b0;
    ram_hab_w  = 1'b0;
    listo      = 1'b0;

    case (estado_q)
      INACTIVO: begin
        if (nucleo.sol) begin
          escribe_d = nucleo.escribe;
          tam_d     = nucleo.tam;
          dir_d     = nucleo.dir[ANCHO_DIR+1:0];
          dato_w_d  = nucleo.dato_in;
          error_d   = err_nuevo;
          if (err_nuevo)                                estado_d = FIN;
          else if (nucleo.escribe && nucleo.tam == TAM_W) estado_d = ESCRIBIR;
          else                                          estado_d = LEER;
        end
      end
      LEER: begin
        ram_hab_r = 1'b1;
        estado_d  = ESPERA;
      end
      ESPERA: begin
        // The same register carries the store data in and the merged word out.
        if (escribe_q) begin
          dato_w_d = fusion;
          estado_d = ESCRIBIR;
        end else begin
          dato_out_d = carga;
          estado_d   = FIN;
        end
      end
      ESCRIBIR: begin
        ram_hab_w = 1'b1;
        estado_d  = FIN;
      end
      FIN: begin
        listo    = 1'b1;
        estado_d = INACTIVO;
      end
      default: estado_d = INACTIVO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= INACTIVO;
      escribe_q  <= 1'b0;
      tam_q      <= 3'b000;
      dir_q      <= '0;
      dato_w_q   <= '0;
      dato_out_q <= '0;
      error_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      escribe_q  <= escribe_d;
      tam_q      <= tam_d;
      dir_q      <= dir_d;
      dato_w_q   <= dato_w_d;
      dato_out_q <= dato_out_d;
      error_q    <= error_d;
    end
  end

  // Enables are decoded from the state register, so reset drops them at once.
  assign ram_dir_r       = dir_q[ANCHO_DIR+1:2];
  assign ram_dir_w       = dir_q[ANCHO_DIR+1:2];
  assign ram_dat_w       = dato_w_q;
  assign nucleo.listo    = listo;
  assign nucleo.error    = error_q;
  assign nucleo.dato_out = dato_out_q;

endmodule

// File: tb/tb_ctrl_ram_datos.sv
// Scoreboard bench for ctrl_ram_datos with a behavioural 512x32 sync RAM.
module tb_ctrl_ram_datos;
  import pkg_mem::*;

  localparam int AD = 9;

  typedef struct {
    logic        err;
    logic [31:0] dout;
    int          lat;
    int          nrd;
    int          nwr;
    logic [8:0]  idx;
  } esperado_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AD-1:0] ram_dir_w, ram_dir_r;
  logic          ram_hab_w, ram_hab_r;
  logic [31:0]   ram_dat_w;
  logic [31:0]   ram_dat_r;

  ctrl_ram_datos_if bus ();

  ctrl_ram_datos #(.ANCHO_DIR(AD)) dut (
    .clk       (clk),
    .rst       (rst),
    .nucleo    (bus),
    .ram_dir_w (ram_dir_w),
    .ram_hab_w (ram_hab_w),
    .ram_dat_w (ram_dat_w),
    .ram_dir_r (ram_dir_r),
    .ram_hab_r (ram_hab_r),
    .ram_dat_r (ram_dat_r)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];
  esperado_t   cola[$];
  logic [31:0] exp_dout = 32'h0;
  int n_checks = 0;
  int n_errors = 0;
  int cnt_pos = 0, n_rd = 0, n_wr = 0, n_listo = 0;
  int t0 = 0, r0 = 0, w0 = 0;

  always @(posedge clk) begin
    if (ram_hab_w) mem[ram_dir_w] <= ram_dat_w;
    if (ram_hab_r) ram_dat_r <= mem[ram_dir_r];
    cnt_pos <= cnt_pos + 1;
    if (ram_hab_r) n_rd <= n_rd + 1;
    if (ram_hab_w) n_wr <= n_wr + 1;
  end

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, esp);
    end
  endtask

  // Monitor: addresses while enables are up, and scoreboard pop on listo.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_hab_r || ram_hab_w) begin
        comprobar("hab_exclusivos", {31'b0, ram_hab_r & ram_hab_w}, 32'h0);
        if (cola.size() > 0) begin
          if (ram_hab_r) comprobar("ram_dir_r", {23'b0, ram_dir_r}, {23'b0, cola[0].idx});
          if (ram_hab_w) comprobar("ram_dir_w", {23'b0, ram_dir_w}, {23'b0, cola[0].idx});
        end
      end
      if (bus.listo) begin
        n_listo++;
        if (cola.size() == 0) begin
          comprobar("listo_espurio", 32'h1, 32'h0);
        end else begin
          esperado_t e;
          e = cola.pop_front();
          comprobar("error",    {31'b0, bus.error}, {31'b0, e.err});
          comprobar("dato_out", bus.dato_out, e.dout);
          comprobar("latencia", cnt_pos - t0 + 1, e.lat);
          comprobar("lecturas", n_rd - r0, e.nrd);
          comprobar("escrituras", n_wr - w0, e.nwr);
        end
      end
    end
  end

  // Reference model: legality, latency, RAM effect and expected load value.
  task automatic modelar(input logic esc, input logic [2:0] tam, input logic [31:0] dir,
                         input logic [31:0] dato, output esperado_t e);
    logic        ilegal, desal, rango;
    logic [8:0]  idx;
    logic [31:0] w, mask;
    int          sh;
    idx    = dir[10:2];
    ilegal = (tam == 3'd3) || (tam >= 3'd6) || (esc && tam[2]);
    desal  = ((tam == 3'd1 || tam == 3'd5) && dir[0]) || (tam == 3'd2 && dir[1:0] != 2'b00);
    rango  = 1'b0;
`ifdef CTRL_RAM_RANGO_EN
    rango = (dir[31:11] != 21'd0);
`endif
    e.idx = idx;
    e.err = ilegal | desal | rango;
    w = ref_mem[idx];
    if (e.err) begin
      e.lat = 2; e.nrd = 0; e.nwr = 0;
    end else if (!esc) begin
      e.lat = 4; e.nrd = 1; e.nwr = 0;
      case (tam)
        3'd0: begin sh = 8 * dir[1:0]; exp_dout = 32'($signed(8'(w >> sh))); end
        3'd4: begin sh = 8 * dir[1:0]; exp_dout = (w >> sh) & 32'hFF; end
        3'd1: begin sh = 16 * dir[1]; exp_dout = 32'($signed(16'(w >> sh))); end
        3'd5: begin sh = 16 * dir[1]; exp_dout = (w >> sh) & 32'hFFFF; end
        default: exp_dout = w;
      endcase
    end else if (tam == 3'd2) begin
      e.lat = 3; e.nrd = 0; e.nwr = 1;
      ref_mem[idx] = dato;
    end else begin
      e.lat = 5; e.nrd = 1; e.nwr = 1;
      if (tam == 3'd0) begin sh = 8 * dir[1:0]; mask = 32'hFF << sh; end
      else begin sh = 16 * dir[1]; mask = 32'hFFFF << sh; end
      ref_mem[idx] = (w & ~mask) | ((dato << sh) & mask);
    end
    e.dout = exp_dout;
  endtask

  task automatic peticion(input logic esc, input logic [2:0] tam, input logic [31:0] dir,
                          input logic [31:0] dato);
    esperado_t e;
    bit        hecho;
    @(negedge clk);
    modelar(esc, tam, dir, dato, e);
    cola.push_back(e);
    t0 = cnt_pos; r0 = n_rd; w0 = n_wr;
    bus.sol = 1'b1; bus.escribe = esc; bus.tam = tam; bus.dir = dir; bus.dato_in = dato;
    hecho = 1'b0;
    for (int i = 0; i < 12 && !hecho; i++) begin
      @(negedge clk);
      if (bus.listo) hecho = 1'b1;
    end
    bus.sol = 1'b0;
    if (!hecho) begin
      comprobar("timeout_listo", 32'h0, 32'h1);
      if (cola.size() > 0) void'(cola.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    esperado_t e_dummy;
    bit        vista;
    int        listo_antes;
    for (int i = 0; i < 512; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    bus.sol = 1'b0; bus.escribe = 1'b0; bus.tam = 3'b000; bus.dir = 32'h0; bus.dato_in = 32'h0;
    repeat (3) @(negedge clk);
    comprobar("rst_listo",    {31'b0, bus.listo}, 32'h0);
    comprobar("rst_error",    {31'b0, bus.error}, 32'h0);
    comprobar("rst_dato_out", bus.dato_out, 32'h0);
    comprobar("rst_habs",     {30'b0, ram_hab_r, ram_hab_w}, 32'h0);
    comprobar("rst_ram_dat_w", ram_dat_w, 32'h0);
    rst = 1'b0;

    peticion(1'b1, TAM_W, 32'h10, 32'hDEADBEEF);
    comprobar("ram4_sw", mem[4], 32'hDEADBEEF);
    peticion(1'b0, TAM_W,  32'h10, 32'h0);
    peticion(1'b0, TAM_B,  32'h13, 32'h0);
    peticion(1'b0, TAM_BU, 32'h13, 32'h0);
    peticion(1'b0, TAM_H,  32'h12, 32'h0);
    peticion(1'b0, TAM_HU, 32'h10, 32'h0);
    peticion(1'b1, TAM_B,  32'h11, 32'h00000012);
    comprobar("ram4_sb", mem[4], 32'hDEAD12EF);
    peticion(1'b0, TAM_W,  32'h10, 32'h0);
    peticion(1'b0, TAM_W,  32'h12, 32'h0);
    peticion(1'b1, TAM_H,  32'h13, 32'h5555);
    peticion(1'b0, 3'b011, 32'h10, 32'h0);
    peticion(1'b1, TAM_BU, 32'h10, 32'h0);
    peticion(1'b1, TAM_H,  32'h22, 32'h1234ABCD);
    peticion(1'b0, TAM_H,  32'h22, 32'h0);
    comprobar("ram4_tras_err", mem[4], 32'hDEAD12EF);

    for (int k = 0; k < 24; k++) begin
      logic [2:0]  t;
      logic [31:0] d;
      case ($urandom_range(0, 4))
        0: t = TAM_B; 1: t = TAM_H; 2: t = TAM_W; 3: t = TAM_BU; default: t = TAM_HU;
      endcase
      d = {($urandom_range(0, 3) == 0) ? 21'($urandom) : 21'd0, 5'd0, 4'($urandom), 2'($urandom)};
      peticion(1'($urandom), t, d, $urandom);
    end
    for (int i = 0; i < 16; i++) comprobar("ram_final", mem[i], ref_mem[i]);

    // Reset during ESCRIBIR of a half-word store: write and listo must not happen.
    @(negedge clk);
    listo_antes = n_listo;
    bus.sol = 1'b1; bus.escribe = 1'b1; bus.tam = TAM_H; bus.dir = 32'h10; bus.dato_in = 32'hAAAA;
    vista = 1'b0;
    for (int i = 0; i < 10 && !vista; i++) begin
      @(negedge clk);
      if (ram_hab_w) vista = 1'b1;
    end
    comprobar("escribir_alcanzado", {31'b0, vista}, 32'h1);
    rst = 1'b1;
    bus.sol = 1'b0;
    #1;
    comprobar("rst_async_hab_w",  {31'b0, ram_hab_w}, 32'h0);
    comprobar("rst_async_listo",  {31'b0, bus.listo}, 32'h0);
    comprobar("rst_async_error",  {31'b0, bus.error}, 32'h0);
    comprobar("rst_async_dout",   bus.dato_out, 32'h0);
    comprobar("rst_async_dat_w",  ram_dat_w, 32'h0);
    exp_dout = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    comprobar("sin_listo_abortado", n_listo - listo_antes, 32'h0);
    comprobar("ram4_sin_escritura", mem[4], ref_mem[4]);
    peticion(1'b0, TAM_W, 32'h10, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
